// File: rtl/debug_ram_wr_arbiter.sv
// Port-A write sequencer for the debug RAM: round-robin arbitration between requesters
// plus a full-RAM clear sweep, with all writes held off while i_access_en is low.
module debug_ram_wr_arbiter #(
   parameter int unsigned NREQ = 2,
   parameter int unsigned AW   = 10,
   parameter int unsigned DW   = 8
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic [NREQ-1:0]           i_req_valid,
   input  logic [NREQ*AW-1:0]        i_req_addr,
   input  logic [NREQ*DW-1:0]        i_req_data,
   output logic [NREQ-1:0]           o_req_ready,
   input  logic                      i_clear_start,
   input  logic                      i_access_en,
   output logic                      o_clear_busy,
   output logic [$clog2(NREQ)-1:0]   o_grant_id,
   output logic                      o_ram_en_a,
   output logic [AW-1:0]             o_ram_addr_a,
   output logic [DW-1:0]             o_ram_data_a
);

   localparam int unsigned GW = $clog2(NREQ);

   typedef enum logic {
      StIdle,
      StClear
   } state_e;

   state_e        r_state;
   logic [GW-1:0] r_ptr;
   logic [AW-1:0] r_cnt;

   logic          w_arb_en;
   logic          w_found;
   logic [GW-1:0] w_sel;
   logic [GW-1:0] w_ptr_nxt;
   logic [AW-1:0] w_sel_addr;
   logic [DW-1:0] w_sel_data;

   // clear_start wins over arbitration even when access_en is low
   assign w_arb_en = (r_state == StIdle) && i_access_en && !i_clear_start;

   // Round-robin scan: first pass covers indices >= ptr, second pass wraps to the rest
   always_comb begin
      w_found = 1'b0;
      w_sel   = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_arb_en && !w_found && i_req_valid[i] && (GW'(i) >= r_ptr)) begin
            w_found = 1'b1;
            w_sel   = GW'(i);
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (w_arb_en && !w_found && i_req_valid[i]) begin
            w_found = 1'b1;
            w_sel   = GW'(i);
         end
      end
   end

   always_comb begin
      o_req_ready = '0;
      w_sel_addr  = '0;
      w_sel_data  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_found && (w_sel == GW'(i))) begin
            o_req_ready[i] = 1'b1;
            w_sel_addr     = i_req_addr[i*AW +: AW];
            w_sel_data     = i_req_data[i*DW +: DW];
         end
      end
   end

   // Explicit wrap so non-power-of-two NREQ cycles correctly
   assign w_ptr_nxt = (w_sel == GW'(NREQ - 1)) ? '0 : w_sel + 1'b1;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= StIdle;
         r_ptr        <= '0;
         r_cnt        <= '0;
         o_clear_busy <= 1'b0;
         o_grant_id   <= '0;
         o_ram_en_a   <= 1'b0;
         o_ram_addr_a <= '0;
         o_ram_data_a <= '0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (i_clear_start) begin
                  r_state      <= StClear;
                  r_cnt        <= '0;
                  o_clear_busy <= 1'b1;
                  o_ram_en_a   <= 1'b0;
               end else if (w_found) begin
                  o_ram_en_a   <= 1'b1;
                  o_ram_addr_a <= w_sel_addr;
                  o_ram_data_a <= w_sel_data;
                  o_grant_id   <= w_sel;
                  r_ptr        <= w_ptr_nxt;
               end else begin
                  o_ram_en_a   <= 1'b0;
               end
            end
            StClear: begin
               if (i_access_en) begin
                  o_ram_en_a   <= 1'b1;
                  o_ram_addr_a <= r_cnt;
                  o_ram_data_a <= '0;
                  r_cnt        <= r_cnt + 1'b1;
                  if (r_cnt == '1) begin
                     r_state      <= StIdle;
                     o_clear_busy <= 1'b0;
                  end
               end else begin
                  o_ram_en_a   <= 1'b0;
               end
            end
            default: begin
               r_state    <= StIdle;
               o_ram_en_a <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_debug_ram_wr_arbiter.sv
// Directed bench for debug_ram_wr_arbiter (NREQ=2, AW=10, DW=8) with a RAM scoreboard.
module tb_debug_ram_wr_arbiter;

   localparam int unsigned NREQ = 2;
   localparam int unsigned AW   = 10;
   localparam int unsigned DW   = 8;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ*AW-1:0]   req_addr;
   logic [NREQ*DW-1:0]   req_data;
   logic [NREQ-1:0]      req_ready;
   logic                 clear_start;
   logic                 access_en;
   logic                 clear_busy;
   logic [0:0]           grant_id;
   logic                 ram_en_a;
   logic [AW-1:0]        ram_addr_a;
   logic [DW-1:0]        ram_data_a;

   logic [DW-1:0]        mem [0:1023];
   int                   n_checks = 0;
   int                   n_fail   = 0;

   debug_ram_wr_arbiter #(
      .NREQ(NREQ),
      .AW  (AW),
      .DW  (DW)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_req_valid  (req_valid),
      .i_req_addr   (req_addr),
      .i_req_data   (req_data),
      .o_req_ready  (req_ready),
      .i_clear_start(clear_start),
      .i_access_en  (access_en),
      .o_clear_busy (clear_busy),
      .o_grant_id   (grant_id),
      .o_ram_en_a   (ram_en_a),
      .o_ram_addr_a (ram_addr_a),
      .o_ram_data_a (ram_data_a)
   );

   always #5 clk = ~clk;

   // Scoreboard RAM: port A commits on the edge ending the cycle ram_en_a is high
   always @(posedge clk) begin
      if (!rst && ram_en_a === 1'b1) mem[ram_addr_a] <= ram_data_a;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset;
      rst = 1'b1; req_valid = '0; clear_start = 1'b0; access_en = 1'b1;
      tick; tick;
      rst = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) begin
         req_valid   = 2'($urandom);
         req_addr    = 20'($urandom);
         req_data    = 16'($urandom);
         clear_start = 1'($urandom);
         access_en   = 1'($urandom);
         tick;
      end
      rst = 1'b0; clear_start = 1'b0; access_en = 1'b1;
      req_valid = 2'b11; req_addr = {10'h2BB, 10'h1AA}; req_data = {8'h22, 8'h11};
      #1;
      n_checks++;
      if (clear_busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_busy got=%0h exp=0", clear_busy);
      end
      n_checks++;
      if (ram_en_a !== 1'b0 || ram_addr_a !== 10'h0 || ram_data_a !== 8'h0 || grant_id !== 1'b0)
      begin
         n_fail++;
         $display("FAIL reset_port got en=%0h addr=%0h data=%0h id=%0h exp all 0",
                  ram_en_a, ram_addr_a, ram_data_a, grant_id);
      end
      n_checks++;
      if (req_ready !== 2'b01) begin
         n_fail++; $display("FAIL reset_first_ready got=%b exp=01", req_ready);
      end
      tick;
      n_checks++;
      if (ram_en_a !== 1'b1 || grant_id !== 1'b0 || ram_addr_a !== 10'h1AA) begin
         n_fail++;
         $display("FAIL reset_first_grant got en=%0h id=%0h addr=%0h exp en=1 id=0 addr=1aa",
                  ram_en_a, grant_id, ram_addr_a);
      end
      req_valid = '0;
      tick;
   endtask

   task automatic test_single;
      req_valid = 2'b01; req_addr = {10'h000, 10'h05A}; req_data = {8'h00, 8'hC3};
      #1;
      n_checks++;
      if (req_ready !== 2'b01) begin
         n_fail++; $display("FAIL single_ready got=%b exp=01", req_ready);
      end
      tick;
      n_checks++;
      if (ram_en_a !== 1'b1 || ram_addr_a !== 10'h05A || ram_data_a !== 8'hC3 ||
          grant_id !== 1'b0) begin
         n_fail++;
         $display("FAIL single_write got en=%0h addr=%0h data=%0h id=%0h exp 1 05a c3 0",
                  ram_en_a, ram_addr_a, ram_data_a, grant_id);
      end
      req_valid = '0;
      tick;
      n_checks++;
      if (ram_en_a !== 1'b0 || ram_addr_a !== 10'h05A || ram_data_a !== 8'hC3) begin
         n_fail++;
         $display("FAIL single_idle got en=%0h addr=%0h data=%0h exp 0 05a c3",
                  ram_en_a, ram_addr_a, ram_data_a);
      end
   endtask

   task automatic test_contention;
      logic       exp_id;
      logic [9:0] exp_addr;
      logic [7:0] exp_data;
      apply_reset;
      req_addr = {10'h222, 10'h111}; req_data = {8'hBB, 8'hAA}; req_valid = 2'b11;
      for (int k = 0; k < 6; k++) begin
         exp_id   = 1'(k % 2);
         exp_addr = exp_id ? 10'h222 : 10'h111;
         exp_data = exp_id ? 8'hBB : 8'hAA;
         #1;
         n_checks++;
         if (req_ready !== (exp_id ? 2'b10 : 2'b01)) begin
            n_fail++; $display("FAIL contend_ready k=%0d got=%b exp_id=%0d", k, req_ready, exp_id);
         end
         tick;
         n_checks++;
         if (ram_en_a !== 1'b1 || grant_id !== exp_id || ram_addr_a !== exp_addr ||
             ram_data_a !== exp_data) begin
            n_fail++;
            $display("FAIL contend_write k=%0d got en=%0h id=%0h addr=%0h data=%0h exp 1 %0h %0h %0h",
                     k, ram_en_a, grant_id, ram_addr_a, ram_data_a, exp_id, exp_addr, exp_data);
         end
      end
      req_valid = '0;
      tick;
   endtask

   task automatic test_clear;
      int n = 0, exp_a = 0, err = 0, rdy_err = 0, nonzero = 0;
      req_valid = 2'b11; access_en = 1'b1; clear_start = 1'b1;
      #1;
      n_checks++;
      if (req_ready !== 2'b00) begin
         n_fail++; $display("FAIL clear_start_ready got=%b exp=00", req_ready);
      end
      tick;
      clear_start = 1'b0;
      n_checks++;
      if (clear_busy !== 1'b1) begin
         n_fail++; $display("FAIL clear_busy_rise got=%0h exp=1", clear_busy);
      end
      while (clear_busy === 1'b1 && n < 2000) begin
         if (req_ready !== 2'b00) rdy_err++;
         tick;
         n++;
         if (ram_en_a !== 1'b1 || ram_addr_a !== 10'(exp_a) || ram_data_a !== 8'h00) err++;
         else exp_a++;
      end
      req_valid = '0;
      tick;
      for (int a = 0; a < 1024; a++) if (mem[a] !== 8'h00) nonzero++;
      n_checks++;
      if (n != 1024) begin
         n_fail++; $display("FAIL clear_busy_len got=%0d exp=1024", n);
      end
      n_checks++;
      if (exp_a != 1024 || err != 0) begin
         n_fail++; $display("FAIL clear_writes got=%0d bad=%0d exp=1024 bad=0", exp_a, err);
      end
      n_checks++;
      if (rdy_err != 0) begin
         n_fail++; $display("FAIL clear_ready got=%0d cycles exp=0", rdy_err);
      end
      n_checks++;
      if (nonzero != 0) begin
         n_fail++; $display("FAIL clear_ram got=%0d nonzero exp=0", nonzero);
      end
      n_checks++;
      if (ram_en_a !== 1'b0) begin
         n_fail++; $display("FAIL clear_done_en got=%0h exp=0", ram_en_a);
      end
   endtask

   task automatic test_collision;
      int n = 0;
      access_en = 1'b1; req_valid = 2'b10;
      req_addr = {10'h3AA, 10'h000}; req_data = {8'h5E, 8'h00}; clear_start = 1'b1;
      #1;
      n_checks++;
      if (req_ready !== 2'b00) begin
         n_fail++; $display("FAIL collide_ready got=%b exp=00", req_ready);
      end
      tick;
      clear_start = 1'b0;
      n_checks++;
      if (clear_busy !== 1'b1 || ram_en_a !== 1'b0) begin
         n_fail++; $display("FAIL collide_enter got busy=%0h en=%0h exp busy=1 en=0",
                            clear_busy, ram_en_a);
      end
      while (clear_busy === 1'b1 && n < 2000) begin
         tick;
         n++;
      end
      n_checks++;
      if (req_ready !== 2'b10) begin
         n_fail++; $display("FAIL collide_post_ready got=%b exp=10", req_ready);
      end
      tick;
      n_checks++;
      if (ram_en_a !== 1'b1 || grant_id !== 1'b1 || ram_addr_a !== 10'h3AA ||
          ram_data_a !== 8'h5E) begin
         n_fail++;
         $display("FAIL collide_serve got en=%0h id=%0h addr=%0h data=%0h exp 1 1 3aa 5e",
                  ram_en_a, grant_id, ram_addr_a, ram_data_a);
      end
      req_valid = '0;
      tick;
   endtask

   task automatic test_access_gating;
      int n = 0, exp_a = 0, err = 0, gap = 0, gap_err = 0;
      bit done = 1'b0;
      access_en = 1'b1; clear_start = 1'b1;
      tick;
      clear_start = 1'b0;
      while (clear_busy === 1'b1 && n < 3000) begin
         access_en = (gap == 0);
         tick;
         n++;
         if (gap > 0) begin
            gap--;
            if (ram_en_a !== 1'b0) gap_err++;
         end else if (ram_en_a !== 1'b1 || ram_addr_a !== 10'(exp_a)) begin
            err++;
         end else begin
            exp_a++;
            if (exp_a == 500 && !done) begin
               gap  = 10;
               done = 1'b1;
            end
         end
      end
      n_checks++;
      if (n != 1034) begin
         n_fail++; $display("FAIL gate_len got=%0d exp=1034", n);
      end
      n_checks++;
      if (gap_err != 0) begin
         n_fail++; $display("FAIL gate_gap_writes got=%0d exp=0", gap_err);
      end
      n_checks++;
      if (err != 0 || exp_a != 1024) begin
         n_fail++; $display("FAIL gate_order got=%0d bad=%0d exp=1024 bad=0", exp_a, err);
      end
      access_en = 1'b0; req_valid = 2'b11;
      #1;
      n_checks++;
      if (req_ready !== 2'b00) begin
         n_fail++; $display("FAIL gate_idle_ready got=%b exp=00", req_ready);
      end
      tick;
      n_checks++;
      if (ram_en_a !== 1'b0) begin
         n_fail++; $display("FAIL gate_idle_en got=%0h exp=0", ram_en_a);
      end
      access_en = 1'b1;
      #1;
      n_checks++;
      if (req_ready !== 2'b01) begin
         n_fail++; $display("FAIL gate_ptr_kept got=%b exp=01", req_ready);
      end
      req_valid = '0;
      tick;
   endtask

   task automatic test_reset_mid;
      access_en = 1'b1; clear_start = 1'b1;
      tick;
      clear_start = 1'b0;
      repeat (5) tick;
      rst = 1'b1;
      tick;
      n_checks++;
      if (clear_busy !== 1'b0 || ram_en_a !== 1'b0 || ram_addr_a !== 10'h0) begin
         n_fail++; $display("FAIL midrst_state got busy=%0h en=%0h addr=%0h exp 0 0 0",
                            clear_busy, ram_en_a, ram_addr_a);
      end
      rst = 1'b0;
      tick;
      n_checks++;
      if (ram_en_a !== 1'b0 || clear_busy !== 1'b0) begin
         n_fail++; $display("FAIL midrst_after got en=%0h busy=%0h exp 0 0", ram_en_a, clear_busy);
      end
   endtask

   initial begin
      for (int a = 0; a < 1024; a++) mem[a] = 8'hFF;
      rst = 1'b1; req_valid = '0; req_addr = '0; req_data = '0;
      clear_start = 1'b0; access_en = 1'b1;
      test_reset;
      test_single;
      test_contention;
      test_clear;
      test_collision;
      test_access_gating;
      test_reset_mid;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
